// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_pkg
// Purpose  : Shared RV32I opcode/funct3 constants, access-size and FSM types.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_NONE = 2'b11
  } access_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    logic bad;
    if (is_store) bad = (f3 >= 3'b011);
    else          bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    return bad;
  endfunction

  // wcode is funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic misaligned(input logic [1:0] wcode, input logic [1:0] lo);
    logic mis;
    case (wcode)
      2'b01:   mis = lo[0];
      2'b10:   mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic access_size_e size_of(input logic [1:0] wcode);
    access_size_e sz;
    case (wcode)
      2'b00:   sz = SZ_BYTE;
      2'b01:   sz = SZ_HALF;
      2'b10:   sz = SZ_WORD;
      default: sz = SZ_NONE;
    endcase
    return sz;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : Combinational store lane replication and load extract/extend.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [1:0]  st_width,
  input  logic [31:0] st_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_word,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sext;

  always_comb begin
    w_byte = ld_word[8*ld_lane +: 8];
    w_half = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
    w_sext = ~ld_funct3[2];

    case (ld_funct3[1:0])
      F3_B[1:0]: ld_value = {{24{w_sext & w_byte[7]}}, w_byte};
      F3_H[1:0]: ld_value = {{16{w_sext & w_half[15]}}, w_half};
      default:   ld_value = ld_word;
    endcase

    case (st_width)
      F3_B[1:0]: st_lanes = {4{st_data[7:0]}};
      F3_H[1:0]: st_lanes = {2{st_data[15:0]}};
      default:   st_lanes = st_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_ctrl
// Purpose  : MEM-stage data-memory access sequencer with timeout and fault check.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        data_mem_ready_n,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_write,
  output logic [1:0]  access_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] load_data,
  output logic        done,
  output logic        access_fault,
  output logic        bus_err,
  output logic        stall
);

  localparam int                 c_cnt_w   = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);

  state_e             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [2:0]         r_funct3;

  logic [c_cnt_w-1:0] w_cnt_inc;
  logic               w_reject;
  logic [31:0]        w_st_lanes;
  logic [31:0]        w_ld_value;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_reject  = f3_illegal(is_store, funct3) | misaligned(funct3[1:0], addr[1:0]);

  // Stall drops in FAULT so the pipeline can advance into the trap.
  assign stall = (start & ((r_state == ST_IDLE) | (r_state == ST_RESP))) | (r_state == ST_REQ);

  lsu_align u_align (
    .st_width  (funct3[1:0]),
    .st_data   (store_data),
    .ld_funct3 (r_funct3),
    .ld_lane   (mem_addr[1:0]),
    .ld_word   (mem_rdata),
    .st_lanes  (w_st_lanes),
    .ld_value  (w_ld_value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_funct3     <= '0;
      mem_req      <= 1'b0;
      mem_write    <= 1'b0;
      access_size  <= SZ_NONE;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      load_data    <= '0;
      done         <= 1'b0;
      access_fault <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      done         <= 1'b0;
      access_fault <= 1'b0;
      bus_err      <= 1'b0;
      case (r_state)
        ST_REQ: begin
          // Ready takes priority over the timeout on the same edge.
          if (!data_mem_ready_n) begin
            r_state     <= ST_RESP;
            done        <= 1'b1;
            if (!mem_write) load_data <= w_ld_value;
            mem_req     <= 1'b0;
            mem_write   <= 1'b0;
            access_size <= SZ_NONE;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == c_timeout) begin
              r_state     <= ST_IDLE;
              bus_err     <= 1'b1;
              mem_req     <= 1'b0;
              mem_write   <= 1'b0;
              access_size <= SZ_NONE;
            end
          end
        end
        ST_FAULT: r_state <= ST_IDLE;
        default: begin
          if (start) begin
            if (w_reject) begin
              r_state      <= ST_FAULT;
              access_fault <= 1'b1;
            end else begin
              r_state     <= ST_REQ;
              r_cnt       <= '0;
              r_funct3    <= funct3;
              mem_req     <= 1'b1;
              mem_write   <= is_store;
              access_size <= size_of(funct3[1:0]);
              mem_addr    <= addr;
              mem_wdata   <= w_st_lanes;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_access_ctrl
// Purpose  : Directed self-checking bench for dmem_access_ctrl (TIMEOUT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        data_mem_ready_n;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic        mem_write;
  logic [1:0]  access_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] load_data;
  logic        done;
  logic        access_fault;
  logic        bus_err;
  logic        stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .is_store         (is_store),
    .funct3           (funct3),
    .addr             (addr),
    .store_data       (store_data),
    .data_mem_ready_n (data_mem_ready_n),
    .mem_rdata        (mem_rdata),
    .mem_req          (mem_req),
    .mem_write        (mem_write),
    .access_size      (access_size),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .load_data        (load_data),
    .done             (done),
    .access_fault     (access_fault),
    .bus_err          (bus_err),
    .stall            (stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in the current cycle (cycle 0).
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input string tag);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    #1;
    chk({tag, ".stall_c0"}, stall, 1);
  endtask

  // Walk the REQ phase: 'waits' cycles with ready_n=1, then one with ready_n=0.
  task automatic req_phase(input int waits, input logic [31:0] rd, input logic wr,
                           input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input string tag);
    tick();
    start = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      data_mem_ready_n = (i == waits) ? 1'b0 : 1'b1;
      mem_rdata        = rd;
      #1;
      chk({tag, ".mem_req"},   mem_req, 1);
      chk({tag, ".mem_write"}, mem_write, wr);
      chk({tag, ".size"},      access_size, sz);
      chk({tag, ".addr"},      mem_addr, a);
      chk({tag, ".wdata"},     mem_wdata, wd);
      chk({tag, ".stall"},     stall, 1);
      chk({tag, ".done_req"},  done, 0);
      tick();
    end
    data_mem_ready_n = 1'b1;
    mem_rdata        = 32'h0;
  endtask

  task automatic resp_check(input logic is_load, input logic [31:0] ld, input string tag);
    #1;
    chk({tag, ".done"},      done, 1);
    chk({tag, ".req_resp"},  mem_req, 0);
    chk({tag, ".size_resp"}, access_size, 2'b11);
    chk({tag, ".wr_resp"},   mem_write, 0);
    if (is_load) chk({tag, ".load_data"}, load_data, ld);
  endtask

  task automatic idle_check(input string tag);
    tick();
    #1;
    chk({tag, ".done_idle"},  done, 0);
    chk({tag, ".req_idle"},   mem_req, 0);
    chk({tag, ".stall_idle"}, stall, 0);
  endtask

  task automatic fault_seq(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input string tag);
    issue(st, f3, a, 32'h0, tag);
    tick();
    #1;
    // start still high in FAULT: must be ignored and must not stall
    chk({tag, ".fault"},       access_fault, 1);
    chk({tag, ".req_fault"},   mem_req, 0);
    chk({tag, ".stall_fault"}, stall, 0);
    tick();
    start = 1'b0;
    #1;
    chk({tag, ".fault_off"}, access_fault, 0);
    chk({tag, ".req_after"}, mem_req, 0);
    tick();
    #1;
    chk({tag, ".fault_off2"}, access_fault, 0);
    chk({tag, ".req_after2"}, mem_req, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0; data_mem_ready_n = 1'b1; mem_rdata = 32'h0;
    tick();
    tick();
    #1;
    chk("rst.mem_req",      mem_req, 0);
    chk("rst.mem_write",    mem_write, 0);
    chk("rst.size",         access_size, 2'b11);
    chk("rst.mem_addr",     mem_addr, 0);
    chk("rst.mem_wdata",    mem_wdata, 0);
    chk("rst.load_data",    load_data, 0);
    chk("rst.done",         done, 0);
    chk("rst.access_fault", access_fault, 0);
    chk("rst.bus_err",      bus_err, 0);
    chk("rst.stall",        stall, 0);
    rst_n = 1'b1;
    tick();

    // LW, immediate ready
    issue(1'b0, 3'b010, 32'h100, 32'h0, "lw");
    req_phase(0, 32'hDEADBEEF, 1'b0, 2'b00, 32'h100, 32'h0, "lw");
    resp_check(1'b1, 32'hDEADBEEF, "lw");
    chk("lw.stall_c2", stall, 0);
    idle_check("lw");

    // Byte / half lane select and extension
    issue(1'b0, 3'b000, 32'h103, 32'h0, "lb");
    req_phase(0, 32'h80FF1234, 1'b0, 2'b10, 32'h103, 32'h0, "lb");
    resp_check(1'b1, 32'hFFFFFF80, "lb");
    idle_check("lb");

    issue(1'b0, 3'b100, 32'h103, 32'h0, "lbu");
    req_phase(0, 32'h80FF1234, 1'b0, 2'b10, 32'h103, 32'h0, "lbu");
    resp_check(1'b1, 32'h00000080, "lbu");
    idle_check("lbu");

    issue(1'b0, 3'b001, 32'h102, 32'h0, "lh");
    req_phase(0, 32'h80FF1234, 1'b0, 2'b01, 32'h102, 32'h0, "lh");
    resp_check(1'b1, 32'hFFFF80FF, "lh");
    idle_check("lh");

    issue(1'b0, 3'b101, 32'h100, 32'h0, "lhu");
    req_phase(0, 32'h80FF1234, 1'b0, 2'b01, 32'h100, 32'h0, "lhu");
    resp_check(1'b1, 32'h00001234, "lhu");
    idle_check("lhu");

    // SH with 3 wait states; ready lands on the timeout edge and wins
    issue(1'b1, 3'b001, 32'h202, 32'h1234ABCD, "sh");
    req_phase(3, 32'h0, 1'b1, 2'b01, 32'h202, 32'hABCDABCD, "sh");
    resp_check(1'b0, 32'h0, "sh");
    chk("sh.bus_err", bus_err, 0);
    idle_check("sh");

    issue(1'b1, 3'b000, 32'h501, 32'h000000A5, "sb");
    req_phase(0, 32'h0, 1'b1, 2'b10, 32'h501, 32'hA5A5A5A5, "sb");
    resp_check(1'b0, 32'h0, "sb");
    idle_check("sb");

    // Misaligned and illegal accesses
    fault_seq(1'b0, 3'b010, 32'h101, "mis_lw");
    fault_seq(1'b0, 3'b001, 32'h201, "mis_lh");
    fault_seq(1'b0, 3'b011, 32'h000, "ill_ld");
    fault_seq(1'b1, 3'b100, 32'h010, "ill_st");

    // Timeout after 4 REQ cycles
    issue(1'b0, 3'b010, 32'h300, 32'h0, "tmo");
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_mem_ready_n = 1'b1;
      #1;
      chk("tmo.mem_req", mem_req, 1);
      chk("tmo.bus_err_early", bus_err, 0);
      tick();
    end
    #1;
    chk("tmo.bus_err",  bus_err, 1);
    chk("tmo.req_off",  mem_req, 0);
    chk("tmo.done",     done, 0);
    chk("tmo.stall",    stall, 0);
    chk("tmo.size",     access_size, 2'b11);
    tick();
    #1;
    chk("tmo.bus_err_off", bus_err, 0);
    chk("tmo.done_off",    done, 0);
    chk("tmo.req_idle",    mem_req, 0);

    // Back-to-back SW then LW, start asserted in RESP
    issue(1'b1, 3'b010, 32'h400, 32'hCAFEF00D, "sw");
    req_phase(1, 32'h0, 1'b1, 2'b00, 32'h400, 32'hCAFEF00D, "sw");
    resp_check(1'b0, 32'h0, "sw");
    issue(1'b0, 3'b010, 32'h404, 32'h0, "b2b_lw");
    req_phase(0, 32'h11223344, 1'b0, 2'b00, 32'h404, 32'h0, "b2b_lw");
    resp_check(1'b1, 32'h11223344, "b2b_lw");
    idle_check("b2b_lw");

    // Asynchronous reset in the middle of REQ
    issue(1'b0, 3'b010, 32'h600, 32'h0, "rst_mid");
    tick();
    start = 1'b0;
    data_mem_ready_n = 1'b1;
    #1;
    chk("rst_mid.req_before", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.req_drop", mem_req, 0);
    chk("rst_mid.size",     access_size, 2'b11);
    chk("rst_mid.stall",    stall, 0);
    tick();
    rst_n = 1'b1;
    data_mem_ready_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_mid.no_done", done, 0);
      chk("rst_mid.no_req",  mem_req, 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
